lfsr7_run_ctrl: RTL and testbench

Sequencer for the 7-bit Fibonacci LFSR datapath. It loads a seed, with all-zero lockup protection, then steps the register under a valid/ready handshake. It emits a programmed number of samples and signals completion. It sits between a host or testbench driver and the sample consumer, e.g. a file writer or checker.

---
 rtl/lfsr7_pkg.sv | 20 ++
 rtl/lfsr7_run_ctrl_if.sv | 12 +
 rtl/lfsr7_core.sv | 37 +++
 rtl/lfsr7_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_lfsr7_run_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr7_pkg.sv
// Shared types, constants and the step function for the 7-bit LFSR run controller.
// Polynomial x^7+x^6+1 (taps at bits 7 and 6, bit 1 is the shift-in end).
package lfsr7_pkg;

    localparam int LFSR_W = 7;
    localparam int TAP_HI = 7;
    localparam int TAP_LO = 6;
    localparam logic [LFSR_W:1] SAFE_SEED_DEF = 7'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [LFSR_W:1] lfsr7_next(input logic [LFSR_W:1] q);
        return {q[LFSR_W-1:1], q[TAP_HI] ^ q[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr7_run_ctrl_if.sv
// Sample stream between the LFSR run controller (master) and its consumer (slave).
interface lfsr7_run_ctrl_if;
    import lfsr7_pkg::*;

    logic [LFSR_W:1] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/lfsr7_core.sv
// 7-bit Fibonacci shift register; load wins over step, reset value is the safe seed.
module lfsr7_core
    import lfsr7_pkg::*;
#(
    parameter logic [LFSR_W:1] SAFE_SEED = SAFE_SEED_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [LFSR_W:1] load_val,
    input  logic            step,
    output logic [LFSR_W:1] q
);

    logic [LFSR_W:1] lfsr_d;
    logic [LFSR_W:1] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = lfsr7_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SAFE_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr7_run_ctrl.sv
// Run controller: loads a seed, emits a programmed number of LFSR samples over a
// valid/ready stream, then pulses done. Define LFSR7_PERIOD_CHECK_EN for period detection.
module lfsr7_run_ctrl
    import lfsr7_pkg::*;
#(
    parameter int              CNT_W     = 8,
    parameter logic [LFSR_W:1] SAFE_SEED = SAFE_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LFSR_W:1]  seed,
    input  logic [CNT_W-1:0] count,
    lfsr7_run_ctrl_if.master strm,
    output logic             busy,
    output logic             done,
    output logic             seed_err,
    output logic             period_hit,
    output logic [LFSR_W:1]  period_len
);

    state_t           state_d, state_q;
    logic [CNT_W-1:0] remaining_d, remaining_q;
    logic             seed_err_d, seed_err_q;
    logic             load;
    logic [LFSR_W:1]  load_val;
    logic             hs;
    logic [LFSR_W:1]  lfsr;

    assign load_val = (seed == '0) ? SAFE_SEED : seed;
    // Abort outranks the consumer: no step or decrement in an abort cycle.
    assign hs = (state_q == RUN) && strm.out_ready && !abort;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        seed_err_d  = seed_err_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load        = 1'b1;
                    remaining_d = count;
                    seed_err_d  = (seed == '0);
                    state_d     = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hs) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seed_err_q  <= seed_err_d;
        end
    end

    lfsr7_core #(
        .SAFE_SEED (SAFE_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .step     (hs),
        .q        (lfsr)
    );

    assign strm.out_data  = lfsr;
    assign strm.out_valid = (state_q == RUN);
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign seed_err       = seed_err_q;

`ifdef LFSR7_PERIOD_CHECK_EN
    logic [LFSR_W:1] base_d, base_q;
    logic [LFSR_W:1] step_cnt_d, step_cnt_q;
    logic [LFSR_W:1] period_len_d, period_len_q;
    logic            period_hit_d, period_hit_q;

    // The hit is registered so it lines up with the cycle the returning state is shown.
    always_comb begin
        base_d       = base_q;
        step_cnt_d   = step_cnt_q;
        period_len_d = period_len_q;
        period_hit_d = 1'b0;
        if (load) begin
            base_d     = load_val;
            step_cnt_d = '0;
        end else if (hs) begin
            if (lfsr7_next(lfsr) == base_q) begin
                period_hit_d = 1'b1;
                period_len_d = step_cnt_q + 1'b1;
                step_cnt_d   = '0;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= SAFE_SEED;
            step_cnt_q   <= '0;
            period_len_q <= '0;
            period_hit_q <= 1'b0;
        end else begin
            base_q       <= base_d;
            step_cnt_q   <= step_cnt_d;
            period_len_q <= period_len_d;
            period_hit_q <= period_hit_d;
        end
    end

    assign period_hit = period_hit_q;
    assign period_len = period_len_q;
`else
    assign period_hit = 1'b0;
    assign period_len = '0;
`endif

endmodule

// File: tb/tb_lfsr7_run_ctrl.sv
// Bench for lfsr7_run_ctrl: directed scenarios plus randomized runs against a
// sample-sequence model built from the polynomial with plain integer arithmetic.
module tb_lfsr7_run_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:1] seed;
    logic [7:0] count;
    logic       busy, done, seed_err, period_hit;
    logic [7:1] period_len;

    lfsr7_run_ctrl_if sif ();

    lfsr7_run_ctrl #(
        .CNT_W     (8),
        .SAFE_SEED (7'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .count      (count),
        .strm       (sif.master),
        .busy       (busy),
        .done       (done),
        .seed_err   (seed_err),
        .period_hit (period_hit),
        .period_len (period_len)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_plen    = 0;
    bit rdy_pat[$];
    int seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int mdl_next(input int q);
        return ((q << 1) & 'h7f) | (((q >> 6) ^ (q >> 5)) & 1);
    endfunction

    // One complete run from IDLE; handshake data is recorded in seen[].
    task automatic run_chk(input int sd, input int cnt, input int pct, input bit noise);
        int cur, base, rem, steps, stall;
        bit rdy, hit_exp, err_exp;
        err_exp = (sd == 0);
        base    = (sd == 0) ? 1 : sd;
        cur     = base;
        rem     = cnt;
        steps   = 0;
        stall   = 0;
        hit_exp = 0;
        seen.delete();
        seed  = 7'(sd);
        count = 8'(cnt);
        start = 1'b1;
        tick;
        start = 1'b0;
        if (cnt == 0) begin
            chk("cnt0_valid", sif.out_valid, 0);
            chk("cnt0_done", done, 1);
            chk("cnt0_err", seed_err, err_exp);
            tick;
            chk("cnt0_done_clr", done, 0);
            return;
        end
        for (int cyc = 0; cyc < 2000 && rem > 0; cyc++) begin
            chk("run_valid", sif.out_valid, 1);
            chk("run_busy", busy, 1);
            chk("run_data", sif.out_data, cur);
            chk("run_done", done, 0);
            chk("run_err", seed_err, err_exp);
            chk("run_hit", period_hit, hit_exp);
            chk("run_plen", period_len, exp_plen);
            if (rdy_pat.size() > 0) rdy = rdy_pat.pop_front();
            else if (stall >= 3)    rdy = 1'b1;
            else                    rdy = ($urandom_range(99) < pct);
            stall = rdy ? 0 : stall + 1;
            if (noise) begin
                start = 1'($urandom_range(1));
                seed  = 7'($urandom);
                count = 8'($urandom);
            end
            sif.out_ready = rdy;
            tick;
            start   = 1'b0;
            hit_exp = 0;
            if (rdy) begin
                seen.push_back(cur);
                cur = mdl_next(cur);
                rem--;
                steps++;
`ifdef LFSR7_PERIOD_CHECK_EN
                if (cur == base) begin
                    hit_exp  = 1;
                    exp_plen = steps;
                    steps    = 0;
                end
`endif
            end
        end
        chk("done_pulse", done, 1);
        chk("done_valid", sif.out_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_data", sif.out_data, cur);
        chk("done_hit", period_hit, hit_exp);
        chk("done_plen", period_len, exp_plen);
        sif.out_ready = 1'b0;
        tick;
        chk("done_clr", done, 0);
        chk("idle_err", seed_err, err_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1[8];
        int t3[4];
        int d0;
        t1 = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h41, 'h03};
        t3 = '{'h01, 'h02, 'h04, 'h08};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        seed = '0; count = '0; sif.out_ready = 1'b0;
        tick;
        tick;
        chk("rst_data", sif.out_data, 'h01);
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", seed_err, 0);
        chk("rst_hit", period_hit, 0);
        chk("rst_plen", period_len, 0);
        rst = 1'b0;
        tick;

        // Directed: seed 01, eight samples at full throughput
        run_chk('h01, 8, 100, 0);
        chk("t1_cnt", seen.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1_seq", seen[i], t1[i]);

        // Zero seed substitution, flag sticky until the next start
        run_chk(0, 3, 100, 0);
        chk("t2_cnt", seen.size(), 3);
        for (int i = 0; i < 3; i++) chk("t2_seq", seen[i], t3[i]);
        tick;
        tick;
        chk("t2_sticky", seed_err, 1);
        run_chk('h05, 2, 100, 0);

        // Back-pressure pattern
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_chk('h01, 4, 100, 0);
        chk("t3_cnt", seen.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_seq", seen[i], t3[i]);

        // Zero count, then start noise during a busy run
        run_chk('h09, 0, 100, 0);
        run_chk('h03, 12, 100, 1);

        // Abort after two samples of a count-10 run
        seed = 7'h11; count = 8'd10; start = 1'b1;
        tick;
        start = 1'b0;
        sif.out_ready = 1'b1;
        chk("ab_s0", sif.out_data, 'h11);
        tick;
        chk("ab_s1", sif.out_data, mdl_next('h11));
        tick;
        d0 = mdl_next(mdl_next('h11));
        chk("ab_s2", sif.out_data, d0);
        abort = 1'b1;
        sif.out_ready = 1'b0;
        tick;
        abort = 1'b0;
        chk("ab_valid", sif.out_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_data", sif.out_data, d0);
        tick;
        chk("ab_done2", done, 0);
        abort = 1'b1; start = 1'b1; seed = 7'h22; count = 8'd5;
        tick;
        abort = 1'b0; start = 1'b0;
        chk("abst_valid", sif.out_valid, 0);
        chk("abst_busy", busy, 0);
        chk("abst_data", sif.out_data, d0);
        tick;
        chk("abst_done", done, 0);
        chk("abst_valid2", sif.out_valid, 0);

        // Reset in the middle of a run
        seed = 7'h00; count = 8'd10; start = 1'b1;
        tick;
        start = 1'b0;
        sif.out_ready = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sif.out_ready = 1'b0;
        exp_plen = 0;
        chk("mr_valid", sif.out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_err", seed_err, 0);
        chk("mr_data", sif.out_data, 'h01);
        chk("mr_hit", period_hit, 0);
        chk("mr_plen", period_len, 0);
        tick;
        chk("mr_done2", done, 0);
        chk("mr_busy2", busy, 0);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int sd;
            sd = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(127));
            run_chk(sd, int'($urandom_range(40)), 70, 1'($urandom_range(1)));
        end

        // Long run across the full 127-state cycle
        run_chk('h55, 200, 100, 0);
        chk("t6_cnt", seen.size(), 200);
        chk("t6_wrap", seen[127], 'h55);
        chk("t6_second", seen[128], mdl_next('h55));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
